// File: rtl/seg_display_arbiter_pkg.sv
// Shared definitions for the 7-segment display arbiter: source indices, state codes,
// the blank pattern and the round-robin selection helpers.
package seg_display_arbiter_pkg;

  localparam logic [1:0] SRC_AUTO   = 2'd0;
  localparam logic [1:0] SRC_SWITCH = 2'd1;
  localparam logic [1:0] SRC_BIT    = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'd0;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One-hot first active request, scanning upward from ptr and wrapping 2->0.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] pick;
    logic [2:0] pos;
    pick = 3'b000;
    for (int i = 0; i < 3; i++) begin
      pos = {1'b0, ptr} + 3'(i);
      pos = (pos >= 3'd3) ? (pos - 3'd3) : pos;
      if ((pick == 3'b000) && req[pos[1:0]]) begin
        pick[pos[1:0]] = 1'b1;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  function automatic logic [1:0] next_ptr(input logic [2:0] winner);
    case (winner)
      3'b001:  return SRC_SWITCH;
      3'b010:  return SRC_BIT;
      default: return SRC_AUTO;
    endcase
  endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Request/pattern bus between the mode logic (master) and the display arbiter (slave).
interface seg_display_arbiter_if;

  logic [2:0] req;
  logic [6:0] segs_0;
  logic [6:0] segs_1;
  logic [6:0] segs_2;
  logic [2:0] grant;
  logic [6:0] segments;
  logic       busy;

  modport master (
    output req, segs_0, segs_1, segs_2,
    input  grant, segments, busy
  );

  modport slave (
    input  req, segs_0, segs_1, segs_2,
    output grant, segments, busy
  );

endinterface

// File: rtl/seg_hold_timer.sv
// Loadable saturating down-counter; o_Done is high once the count has reached zero.
// Times both the dwell of a grant and the blank gap between grants.
module seg_hold_timer #(
  parameter int g_WIDTH = 4
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Load,
  input  logic [g_WIDTH-1:0] i_Value,
  output logic               o_Done
);

  logic [g_WIDTH-1:0] count_q;
  logic [g_WIDTH-1:0] count_d;
  logic               done_q;

  // Next count: load, count down, or hold at zero.
  always_comb begin
    count_d = count_q;
    if (i_Load) begin
      count_d = i_Value;
    end else if (count_q != {g_WIDTH{1'b0}}) begin
      count_d = count_q - g_WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count and done flag registers.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      count_q <= {g_WIDTH{1'b0}};
      done_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      done_q  <= (count_d == {g_WIDTH{1'b0}});
    end
  end

  assign o_Done = done_q;

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter with minimum dwell sharing one 7-segment display between three sources.
// Optional blank gap between grants when SEG_ARB_GAP_EN is defined.
module seg_display_arbiter
  import seg_display_arbiter_pkg::*;
#(
  parameter int g_HOLD = 4000000,
  parameter int g_GAP  = 2500000
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  seg_display_arbiter_if.slave  arb_if
);

  localparam int TW = $clog2(max_int(g_HOLD, g_GAP)) + 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(g_HOLD - 1);
`ifdef SEG_ARB_GAP_EN
  localparam logic [TW-1:0] GAP_LOAD = TW'(g_GAP - 1);
`endif

  arb_state_e    state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [6:0]    segments_q, segments_d;
  logic          busy_q;
  logic [2:0]    others_s;
  logic [2:0]    pick_s;
  logic          owner_live_s;
  logic          timer_done_s;
  logic          load_s;
  logic [TW-1:0] value_s;

  seg_hold_timer #(.g_WIDTH(TW)) u_timer (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Load  (load_s),
    .i_Value (value_s),
    .o_Done  (timer_done_s)
  );

  // Next owner, pointer and timer reload; grant_q is zero outside GRANT so others_s is the full request set there.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    load_s       = 1'b0;
    value_s      = HOLD_LOAD;
    others_s     = arb_if.req & ~grant_q;
    owner_live_s = |(arb_if.req & grant_q);
    pick_s       = rr_pick(others_s, ptr_q);
    case (state_q)
      ARB_IDLE: begin
        if (pick_s != 3'b000) begin
          state_d = ARB_GRANT;
          grant_d = pick_s;
          ptr_d   = next_ptr(pick_s);
          load_s  = 1'b1;
        end else begin
          grant_d = 3'b000;
        end
      end
      ARB_GRANT: begin
        if (!owner_live_s || (timer_done_s && (pick_s != 3'b000))) begin
`ifdef SEG_ARB_GAP_EN
          state_d = ARB_GAP;
          grant_d = 3'b000;
          load_s  = 1'b1;
          value_s = GAP_LOAD;
`else
          if (pick_s != 3'b000) begin
            grant_d = pick_s;
            ptr_d   = next_ptr(pick_s);
            load_s  = 1'b1;
          end else begin
            state_d = ARB_IDLE;
            grant_d = 3'b000;
          end
`endif
        end else begin
          grant_d = grant_q;
        end
      end
      ARB_GAP: begin
`ifdef SEG_ARB_GAP_EN
        if (timer_done_s && (pick_s != 3'b000)) begin
          state_d = ARB_GRANT;
          grant_d = pick_s;
          ptr_d   = next_ptr(pick_s);
          load_s  = 1'b1;
        end else if (timer_done_s) begin
          state_d = ARB_IDLE;
          grant_d = 3'b000;
        end else begin
          grant_d = 3'b000;
        end
`else
        state_d = ARB_IDLE;
        grant_d = 3'b000;
`endif
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  // Pattern follows the owner chosen at this same edge, so a new owner is shown with no extra delay.
  always_comb begin
    case (grant_d)
      3'b001:  segments_d = arb_if.segs_0;
      3'b010:  segments_d = arb_if.segs_1;
      3'b100:  segments_d = arb_if.segs_2;
      default: segments_d = SEG_BLANK;
    endcase
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= ARB_IDLE;
      grant_q    <= 3'b000;
      ptr_q      <= SRC_AUTO;
      segments_q <= SEG_BLANK;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      segments_q <= segments_d;
      busy_q     <= (grant_d != 3'b000);
    end
  end

  assign arb_if.grant    = grant_q;
  assign arb_if.segments = segments_q;
  assign arb_if.busy     = busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter (g_HOLD=4, g_GAP=2); honours SEG_ARB_GAP_EN.
module tb_seg_display_arbiter;

  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic clk = 1'b0;
  logic rst;

  seg_display_arbiter_if bus ();

  seg_display_arbiter #(.g_HOLD(HOLD), .g_GAP(GAP)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .arb_if  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] grant;
    logic [6:0] segs;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: owner index (-1 = none), rr pointer, edges since grant, gap edges left.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  int m_gap   = 0;

  task automatic check(input string name, input logic [2:0] g, input logic [6:0] s,
                       input logic b, input exp_t e);
    tests++;
    if ({g, s, b} !== e) begin
      fails++;
      $display("FAIL %s @%0t: got grant=%b segs=%h busy=%b, want grant=%b segs=%h busy=%b",
               name, $time, g, s, b, e.grant, e.segs, e.busy);
    end
  endtask

  function automatic int m_pick(input logic [2:0] r, input int excl);
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (m_ptr + k) % 3;
      if (r[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  task automatic m_begin(input int w);
    m_owner = w;
    m_ptr   = (w + 1) % 3;
    m_held  = 0;
  endtask

  task automatic m_end(input int w);
`ifdef SEG_ARB_GAP_EN
    m_owner = -1;
    m_gap   = GAP;
`else
    if (w >= 0) m_begin(w);
    else m_owner = -1;
`endif
  endtask

  task automatic m_edge(input logic [2:0] r);
    int w;
    if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) begin
        w = m_pick(r, -1);
        if (w >= 0) m_begin(w);
      end
    end else if (m_owner < 0) begin
      w = m_pick(r, -1);
      if (w >= 0) m_begin(w);
    end else begin
      m_held++;
      w = m_pick(r, m_owner);
      if (!r[m_owner] || (m_held >= HOLD && w >= 0)) m_end(w);
    end
  endtask

  // Called at a negedge: drive inputs, predict the post-edge outputs, wait for the next negedge.
  task automatic step(input logic [2:0] r, input logic [6:0] a, input logic [6:0] b,
                      input logic [6:0] c);
    exp_t e;
    bus.req    = r;
    bus.segs_0 = a;
    bus.segs_1 = b;
    bus.segs_2 = c;
    m_edge(r);
    e.grant = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
    e.segs  = (m_owner == 0) ? a : (m_owner == 1) ? b : (m_owner == 2) ? c : 7'd0;
    e.busy  = (m_owner >= 0);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic rstep(input logic [2:0] r);
    step(r, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
         7'($urandom_range(0, 127)));
  endtask

  // Monitor: compare every post-edge output against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", bus.grant, bus.segments, bus.busy, e);
      end
    end
  end

  initial begin
    logic [2:0] r;
    rst        = 1'b1;
    bus.req    = 3'b000;
    bus.segs_0 = 7'd0;
    bus.segs_1 = 7'd0;
    bus.segs_2 = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", bus.grant, bus.segments, bus.busy, '0);
    @(negedge clk);
    rst = 1'b0;

    // Single source, then release.
    repeat (6) step(3'b001, 7'h3F, 7'h06, 7'h5B);
    repeat (2) step(3'b000, 7'h3F, 7'h06, 7'h5B);
    // Two and three sources contending.
    repeat (13) step(3'b011, 7'h3F, 7'h06, 7'h5B);
    repeat (2) step(3'b000, 7'h11, 7'h22, 7'h33);
    repeat (17) rstep(3'b111);
    repeat (2) rstep(3'b000);
    // Early drop by the owner.
    repeat (2) rstep(3'b101);
    repeat (4) rstep(3'b100);
    repeat (2) rstep(3'b000);

    // Asynchronous reset mid-grant, then 110 from pointer 0.
    repeat (3) step(3'b011, 7'h3F, 7'h06, 7'h5B);
    @(posedge clk);
    #3;
    rst     = 1'b1;
    bus.req = 3'b000;
    #1;
    check("reset_mid_grant", bus.grant, bus.segments, bus.busy, '0);
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_gap   = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) step(3'b110, 7'h3F, 7'h06, 7'h5B);

    // Random sticky requests.
    r = 3'b000;
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < 3; j++) begin
        if ($urandom_range(0, 5) == 0) r[j] = ~r[j];
      end
      rstep(r);
    end
    repeat (4) rstep(3'b000);

    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending predictions, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
